// File: rtl/engine_alu_ops_operand_packer_if.sv
// Operand stream in, packed multi-field packet out, between the packer and its neighbours.
// The slave modport is the packer's view of the bus; the master modport is the environment's view.
interface engine_alu_ops_operand_packer_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 4
);
  logic                         in_valid;
  logic [DATA_W-1:0]            in_data;
  logic                         in_last;
  logic                         in_ready;
  logic                         out_valid;
  logic [NUM_FIELDS*DATA_W-1:0] out_data;
  logic [NUM_FIELDS-1:0]        out_field_mask;
  logic                         out_short;
  logic                         out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_field_mask, out_short
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_field_mask, out_short
  );
endinterface

// File: rtl/engine_alu_ops_operand_packer.sv
// Gathers single-word operands into one NUM_FIELDS-wide packet for the ALU-ops kernel.
// A packet closes after field_count words or early on in_last; unused fields read zero.
module engine_alu_ops_operand_packer #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 4,
  parameter int CNT_W      = $clog2(NUM_FIELDS + 1)
) (
  input  logic                                 ap_clk,
  input  logic                                 areset_n,
  input  logic                                 clear,
  input  logic                                 config_valid,
  input  logic [CNT_W-1:0]                     field_count,
  output logic                                 cfg_error,
  engine_alu_ops_operand_packer_if.slave       bus
);

  localparam int IDX_W = $clog2(NUM_FIELDS);

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    EMIT
  } state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [NUM_FIELDS-1:0][DATA_W-1:0]  fields_q, fields_d;
  logic [NUM_FIELDS-1:0]              mask_q, mask_d;
  logic                               short_q, short_d;
  logic                               cfg_err_q, cfg_err_d;

  logic cfg_legal;
  logic last_slot;

  assign cfg_legal = (field_count != '0) && (field_count <= CNT_W'(NUM_FIELDS));
  assign last_slot = (CNT_W'(idx_q) == cnt_q - CNT_W'(1));

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path leaves it unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fields_d  = fields_q;
    mask_d    = mask_q;
    short_d   = short_q;
    cfg_err_d = cfg_err_q;

    unique case (state_q)
      IDLE: begin
        if (config_valid) begin
          if (cfg_legal) begin
            cnt_d   = field_count;
            state_d = GATHER;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      GATHER: begin
        if (bus.in_valid) begin
          fields_d[idx_q] = bus.in_data;
          mask_d[idx_q]   = 1'b1;
          if (last_slot || bus.in_last) begin
            state_d = EMIT;
            short_d = bus.in_last && !last_slot;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      EMIT: begin
        if (bus.out_ready) begin
          fields_d = '0;
          mask_d   = '0;
          short_d  = 1'b0;
          idx_d    = '0;
          // A count presented during the packet only takes effect here, at the handshake.
          if (!config_valid) begin
            state_d = GATHER;
          end else if (cfg_legal) begin
            cnt_d   = field_count;
            state_d = GATHER;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Flush outranks every handshake; a pending packet is simply dropped.
    if (clear) begin
      state_d   = IDLE;
      idx_d     = '0;
      fields_d  = '0;
      mask_d    = '0;
      short_d   = 1'b0;
      cfg_err_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      // NOTE: the field storage is reset too, so a packet torn by reset never leaks partial operands.
      fields_q  <= '0;
      mask_q    <= '0;
      short_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep all registers sampling the same pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      fields_q  <= fields_d;
      mask_q    <= mask_d;
      short_q   <= short_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.in_ready       = (state_q == GATHER);
  assign bus.out_valid      = (state_q == EMIT);
  assign bus.out_data       = fields_q;
  assign bus.out_field_mask = mask_q;
  assign bus.out_short      = short_q;
  assign cfg_error          = cfg_err_q;

endmodule

// File: tb/tb_engine_alu_ops_operand_packer.sv
// Directed bench for engine_alu_ops_operand_packer: full, short, backpressure,
// bad config, clear and asynchronous reset, all against hand-computed values.
module tb_engine_alu_ops_operand_packer;

  localparam int DATA_W     = 32;
  localparam int NUM_FIELDS = 4;
  localparam int CNT_W      = $clog2(NUM_FIELDS + 1);

  logic             ap_clk = 1'b0;
  logic             areset_n;
  logic             clear;
  logic             config_valid;
  logic [CNT_W-1:0] field_count;
  logic             cfg_error;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [127:0] held_data;

  engine_alu_ops_operand_packer_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS)) bus ();

  engine_alu_ops_operand_packer #(
    .DATA_W     (DATA_W),
    .NUM_FIELDS (NUM_FIELDS),
    .CNT_W      (CNT_W)
  ) dut (
    .ap_clk       (ap_clk),
    .areset_n     (areset_n),
    .clear        (clear),
    .config_valid (config_valid),
    .field_count  (field_count),
    .cfg_error    (cfg_error),
    .bus          (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic configure(input logic [CNT_W-1:0] cnt);
    config_valid = 1'b1;
    field_count  = cnt;
    step();
    config_valid = 1'b0;
  endtask

  initial begin
    areset_n      = 1'b0;
    clear         = 1'b0;
    config_valid  = 1'b0;
    field_count   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) step();
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_cfg_error", cfg_error,     0);
    areset_n = 1'b1;
    step();

    // Full packet of four, back-to-back.
    configure(3'd4);
    check("full_gather_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    check("full_no_early_valid", bus.out_valid, 0);
    send(32'h44, 1'b0);
    check("full_valid",    bus.out_valid,      1);
    check("full_data",     bus.out_data,       128'h00000044_00000033_00000022_00000011);
    check("full_mask",     bus.out_field_mask, 4'b1111);
    check("full_short",    bus.out_short,      0);
    check("full_in_ready", bus.in_ready,       0);
    step();
    check("full_done_valid", bus.out_valid,      0);
    check("full_done_ready", bus.in_ready,       1);
    check("full_done_data",  bus.out_data,       0);
    check("full_done_mask",  bus.out_field_mask, 0);

    // Short packet closed by in_last on the second word, held under backpressure.
    bus.out_ready = 1'b0;
    send(32'hA, 1'b0);
    send(32'hB, 1'b1);
    held_data = 128'h00000000_00000000_0000000B_0000000A;
    check("short_valid", bus.out_valid,      1);
    check("short_data",  bus.out_data,       held_data);
    check("short_mask",  bus.out_field_mask, 4'b0011);
    check("short_flag",  bus.out_short,      1);

    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid",    bus.out_valid,      1);
      check("bp_data",     bus.out_data,       held_data);
      check("bp_mask",     bus.out_field_mask, 4'b0011);
      check("bp_short",    bus.out_short,      1);
      check("bp_in_ready", bus.in_ready,       0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready,  1);
    check("bp_release_data",  bus.out_data,  0);

    // in_last on the first word: one-field short packet; relatch count 2 on its handshake.
    send(32'h55, 1'b1);
    check("one_data",  bus.out_data,       128'h55);
    check("one_mask",  bus.out_field_mask, 4'b0001);
    check("one_short", bus.out_short,      1);
    configure(3'd2);
    check("relatch_valid", bus.out_valid, 0);
    check("relatch_ready", bus.in_ready,  1);

    // in_last on the count-th word is a normal close.
    send(32'h66, 1'b0);
    check("cnt2_not_yet", bus.out_valid, 0);
    send(32'h77, 1'b1);
    check("cnt2_valid", bus.out_valid,      1);
    check("cnt2_data",  bus.out_data,       128'h00000077_00000066);
    check("cnt2_mask",  bus.out_field_mask, 4'b0011);
    check("cnt2_short", bus.out_short,      0);

    // Illegal count presented at the handshake drops to IDLE with the error set.
    configure(3'd5);
    check("bad_relatch_ready", bus.in_ready,  0);
    check("bad_relatch_valid", bus.out_valid, 0);
    check("bad_relatch_err",   cfg_error,     1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("bad_relatch_clear", cfg_error, 0);

    // field_count of zero in IDLE.
    configure(3'd0);
    check("zero_err",   cfg_error,    1);
    check("zero_ready", bus.in_ready, 0);
    step();
    check("zero_stays_idle", bus.in_ready, 0);
    check("zero_sticky",     cfg_error,    1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("zero_clear", cfg_error, 0);

    // Clear after two of four words, colliding with a third accepted word.
    configure(3'd4);
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3;
    clear        = 1'b1;
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_in_ready", bus.in_ready,       0);
    check("clr_valid",    bus.out_valid,      0);
    check("clr_data",     bus.out_data,       0);
    check("clr_mask",     bus.out_field_mask, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("clr_no_valid", bus.out_valid, 0);
    end
    configure(3'd2);
    send(32'hC1, 1'b0);
    send(32'hC2, 1'b0);
    check("clr_next_data",  bus.out_data,       128'h000000C2_000000C1);
    check("clr_next_mask",  bus.out_field_mask, 4'b0011);
    check("clr_next_short", bus.out_short,      0);
    step();

    // Asynchronous reset in the middle of a gather cycle.
    send(32'hE1, 1'b0);
    check("arst_partial", bus.out_data, 128'hE1);
    #2;
    areset_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready,       0);
    check("arst_valid",    bus.out_valid,      0);
    check("arst_data",     bus.out_data,       0);
    check("arst_mask",     bus.out_field_mask, 0);
    step();
    areset_n = 1'b1;
    configure(3'd1);
    send(32'hF0, 1'b0);
    check("cnt1_valid", bus.out_valid,      1);
    check("cnt1_data",  bus.out_data,       128'hF0);
    check("cnt1_mask",  bus.out_field_mask, 4'b0001);
    check("cnt1_short", bus.out_short,      0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
